// File: rtl/pe_ram_responder.sv
// Shared word RAM behind a round-robin arbiter. At most one PE request is served per cycle.
// The response (valid strobe, read data, range error) is registered one cycle after the grant.
module pe_ram_responder #(
  parameter int RAM_SIZE = 128,
  parameter int PE_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PE_COUNT-1:0]   req_valid,
  input  logic [PE_COUNT-1:0]   req_we,
  input  logic [PE_COUNT*32-1:0] req_addr,
  input  logic [PE_COUNT*32-1:0] req_wdata,
  output logic [PE_COUNT-1:0]   req_ready,
  output logic [PE_COUNT-1:0]   rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int PTR_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int AW    = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

  logic [31:0]         ram [RAM_SIZE];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic                grant_found;
  logic                grant_ok;
  logic [PE_COUNT-1:0] grant_vec;
  int                  scan_idx;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic                in_range;
  logic [AW-1:0]       ram_idx;
  logic                wr_en;

  // Scan from rr_ptr upward (wrapping) and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < PE_COUNT; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= PE_COUNT) scan_idx = scan_idx - PE_COUNT;
      if (!grant_found && req_valid[PTR_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    grant_vec = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
        grant_vec[i] = grant_found;
      end
    end
  end

  // Every address bit takes part in the range check, so large addresses never alias into the RAM.
  assign in_range  = (sel_addr < 32'(RAM_SIZE));
  assign ram_idx   = sel_addr[AW-1:0];
  assign grant_ok  = grant_found && rst_n;
  assign wr_en     = grant_ok && sel_we && in_range;
  assign req_ready = rst_n ? grant_vec : '0;
  assign next_ptr  = (grant_idx == PTR_W'(PE_COUNT - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) ram[ram_idx] <= sel_wdata;
  end

  // The read samples the pre-edge RAM word, so a same-edge write is never visible here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant_ok) rr_ptr <= next_ptr;
      rsp_valid <= grant_vec;
      rsp_err   <= grant_found && !in_range;
      rsp_rdata <= (grant_found && !sel_we && in_range) ? ram[ram_idx] : '0;
    end
  end

endmodule
